spi_peripheral: RTL



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_peripheral_if.sv | 10 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/spi_peripheral.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI register target.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between the pin mux (host side) and the register target.
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/sync_edge_det.sv
// N-stage synchronizer for one asynchronous pin, with single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI Mode 0 write target feeding the PWM register bank; all pins are oversampled by clk.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_peripheral_if.slave  spi,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle,
  output logic             frame_err
);

  localparam logic [4:0] CntFull = 5'(FRAME_BITS);
  localparam logic [4:0] CntSat  = 5'(FRAME_BITS + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi.sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi.copi),
    .q    (copi_s),
    .rise (copi_rise),
    .fall (copi_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi.ncs),
    .q    (ncs_s),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  state_t                state;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  rw;
  logic [6:0]            addr;
  logic [7:0]            data;

  assign rw   = shreg[FRAME_BITS-1];
  assign addr = shreg[FRAME_BITS-2 -: 7];
  assign data = shreg[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      bit_cnt         <= '0;
      shreg           <= '0;
      frame_err       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          frame_err <= 1'b0;
          if (ncs_fall) begin
            state   <= StShift;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        StShift: begin
          // A clock edge coinciding with deselect is dropped, not counted.
          if (ncs_rise) begin
            state     <= StCommit;
            frame_err <= (bit_cnt != CntFull);
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != CntSat) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        StCommit: begin
          state     <= StIdle;
          frame_err <= 1'b0;
          if (bit_cnt == CntFull && rw && addr <= MAX_ADDR) begin
            case (addr)
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= data;
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= data;
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= data;
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= data;
              ADDR_DUTY:      pwm_duty_cycle  <= data;
              default: ;
            endcase
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       rd_active;
  logic [7:0] rd_shift;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;

  // Address as it stands once the 8th bit lands, before it reaches shreg.
  assign rd_addr = {shreg[5:0], copi_s};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
      ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
      ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
      ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
      ADDR_DUTY:      rd_data = pwm_duty_cycle;
      default:        rd_data = '0;
    endcase
  end

  // The fall right after the 8th rise precedes the host's bit-7 sample, so shifting starts later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_active <= 1'b0;
      rd_shift  <= '0;
    end else if (state != StShift) begin
      rd_active <= 1'b0;
    end else if (!ncs_rise && sclk_rise && bit_cnt == 5'd7) begin
      rd_active <= !shreg[6] && (rd_addr <= MAX_ADDR);
      rd_shift  <= rd_data;
    end else if (rd_active && sclk_fall && bit_cnt >= 5'd9) begin
      rd_shift <= {rd_shift[6:0], 1'b0};
    end
  end

  assign spi.cipo = rd_active & ~ncs_s & rd_shift[7];

  logic unused;
  assign unused = &{1'b0, sclk_s, copi_rise, copi_fall};
`else
  assign spi.cipo = 1'b0;

  logic unused;
  assign unused = &{1'b0, sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s};
`endif

endmodule
